// File: rtl/ppg_window_stats_if.sv
// PPG window stats bus: sample strobes and enable in, window results out.
// master: sample source / consumer; slave: the stats block.
interface ppg_window_stats_if;
  logic       Enable;
  logic [7:0] RED_ADC_Value;
  logic       RED_Valid;
  logic [7:0] IR_ADC_Value;
  logic       IR_Valid;
  logic [7:0] RED_AC;
  logic [7:0] RED_DC;
  logic [7:0] IR_AC;
  logic [7:0] IR_DC;
  logic [7:0] Beat_Count;
  logic       Stats_Valid;
  logic       Busy;

  modport master (
    output Enable, RED_ADC_Value, RED_Valid,
    output IR_ADC_Value, IR_Valid,
    input  RED_AC, RED_DC, IR_AC, IR_DC,
    input  Beat_Count, Stats_Valid, Busy
  );

  modport slave (
    input  Enable, RED_ADC_Value, RED_Valid,
    input  IR_ADC_Value, IR_Valid,
    output RED_AC, RED_DC, IR_AC, IR_DC,
    output Beat_Count, Stats_Valid, Busy
  );
endinterface

// File: rtl/ppg_window_stats.sv
// Per-window RED/IR AC (max-min), DC (mean) and IR beat count.
// Ports: CLK, rst (async high), bus (slave: strobes in, stats out).
module ppg_window_stats #(
  parameter int WIN_LOG2 = 6,
  parameter int HYST     = 8
) (
  input logic CLK,
  input logic rst,
  ppg_window_stats_if.slave bus
);
  localparam int CW = WIN_LOG2 + 1;
  localparam int SW = WIN_LOG2 + 8;
  localparam logic [CW-1:0] N = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [7:0] HY = 8'(HYST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LATCH
  } state_t;

  state_t        state;
  logic [CW-1:0] red_cnt, ir_cnt;
  logic [SW-1:0] red_sum, ir_sum;
  logic [7:0]    red_min, red_max;
  logic [7:0]    ir_min, ir_max;
  logic [7:0]    beat;
  logic          pk_down;
  logic          pk_first;
  logic [7:0]    pk_t;

  logic       red_take, ir_take;
  logic [7:0] red_s, ir_s;

  assign red_s    = bus.RED_ADC_Value;
  assign ir_s     = bus.IR_ADC_Value;
  assign red_take = bus.RED_Valid && (red_cnt != N);
  assign ir_take  = bus.IR_Valid && (ir_cnt != N);
  assign bus.Busy = (state != S_IDLE);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      red_cnt         <= '0;
      ir_cnt          <= '0;
      red_sum         <= '0;
      ir_sum          <= '0;
      red_min         <= 8'hFF;
      red_max         <= '0;
      ir_min          <= 8'hFF;
      ir_max          <= '0;
      beat            <= '0;
      pk_down         <= 1'b0;
      pk_first        <= 1'b0;
      pk_t            <= '0;
      bus.RED_AC      <= '0;
      bus.RED_DC      <= '0;
      bus.IR_AC       <= '0;
      bus.IR_DC       <= '0;
      bus.Beat_Count  <= '0;
      bus.Stats_Valid <= 1'b0;
    end else begin
      bus.Stats_Valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.Enable) begin
            state    <= S_ACQ;
            pk_first <= 1'b1;
            pk_down  <= 1'b0;
          end
        end
        S_ACQ: begin
          if (!bus.Enable) begin
            state <= S_IDLE;
          end else begin
            if (red_cnt == N && ir_cnt == N)
              state <= S_LATCH;
            if (red_take) begin
              red_cnt <= red_cnt + 1'b1;
              red_sum <= red_sum + SW'(red_s);
              if (red_s < red_min) red_min <= red_s;
              if (red_s > red_max) red_max <= red_s;
            end
            if (ir_take) begin
              ir_cnt <= ir_cnt + 1'b1;
              ir_sum <= ir_sum + SW'(ir_s);
              if (ir_s < ir_min) ir_min <= ir_s;
              if (ir_s > ir_max) ir_max <= ir_s;
              // First sample after a fresh start only seeds the tracker.
              if (pk_first) begin
                pk_first <= 1'b0;
                pk_t     <= ir_s;
              end else if (!pk_down) begin
                if (ir_s > pk_t) begin
                  pk_t <= ir_s;
                end else if ((pk_t - ir_s) >= HY) begin
                  if (beat != 8'hFF) beat <= beat + 8'd1;
                  pk_down <= 1'b1;
                  pk_t    <= ir_s;
                end
              end else begin
                if (ir_s < pk_t) begin
                  pk_t <= ir_s;
                end else if ((ir_s - pk_t) >= HY) begin
                  pk_down <= 1'b0;
                  pk_t    <= ir_s;
                end
              end
            end
          end
        end
        S_LATCH: begin
          bus.RED_AC      <= red_max - red_min;
          bus.RED_DC      <= red_sum[SW-1:WIN_LOG2];
          bus.IR_AC       <= ir_max - ir_min;
          bus.IR_DC       <= ir_sum[SW-1:WIN_LOG2];
          bus.Beat_Count  <= beat;
          bus.Stats_Valid <= 1'b1;
          state <= bus.Enable ? S_ACQ : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Accumulators sit cleared outside ACQUIRE so every window
      // starts fresh; LATCH still reads the old values this edge.
      if (state != S_ACQ) begin
        red_cnt <= '0;
        ir_cnt  <= '0;
        red_sum <= '0;
        ir_sum  <= '0;
        red_min <= 8'hFF;
        red_max <= '0;
        ir_min  <= 8'hFF;
        ir_max  <= '0;
        beat    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ppg_window_stats.sv
// Bench for ppg_window_stats: directed + random windows vs a
// queue-based window model and peak-detector reference.
module tb_ppg_window_stats;
  localparam int WL = 6;
  localparam int N  = 1 << WL;
  localparam int HY = 8;

  logic CLK;
  logic rst;
  ppg_window_stats_if bus ();

  ppg_window_stats #(
    .WIN_LOG2(WL),
    .HYST    (HY)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int sv_pulses = 0;

  int rq[$];
  int iq[$];
  bit m_act;
  bit m_first;
  bit m_down;
  int m_t;
  int m_beat;
  int e_rac, e_rdc, e_iac, e_idc, e_beat;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.Stats_Valid === 1'b1) sv_pulses++;
  endtask

  function automatic void win_stats(input int q[$], output int ac,
                                    output int dc);
    int mn, mx, s;
    mn = 255; mx = 0; s = 0;
    foreach (q[i]) begin
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
      s += q[i];
    end
    ac = mx - mn;
    dc = s / N;
  endfunction

  task automatic pk_model(input int s);
    if (m_first) begin
      m_t = s;
      m_first = 0;
    end else if (!m_down) begin
      if (s > m_t) m_t = s;
      else if (m_t - s >= HY) begin
        if (m_beat < 255) m_beat++;
        m_down = 1;
        m_t = s;
      end
    end else begin
      if (s < m_t) m_t = s;
      else if (s - m_t >= HY) begin
        m_down = 0;
        m_t = s;
      end
    end
  endtask

  task automatic fresh_start();
    rq.delete();
    iq.delete();
    m_act = 1;
    m_first = 1;
    m_down = 0;
    m_beat = 0;
  endtask

  task automatic send(input bit rv, input int rd, input bit iv,
                      input int id);
    bus.RED_Valid     = rv;
    bus.RED_ADC_Value = 8'(rd);
    bus.IR_Valid      = iv;
    bus.IR_ADC_Value  = 8'(id);
    if (m_act) begin
      if (rv && rq.size() < N) rq.push_back(rd & 255);
      if (iv && iq.size() < N) begin
        iq.push_back(id & 255);
        pk_model(id & 255);
      end
    end
    tick();
    bus.RED_Valid = 1'b0;
    bus.IR_Valid  = 1'b0;
  endtask

  task automatic junk_on();
    bus.RED_Valid     = 1'b1;
    bus.RED_ADC_Value = 8'($urandom_range(0, 255));
    bus.IR_Valid      = 1'b1;
    bus.IR_ADC_Value  = 8'($urandom_range(0, 255));
  endtask

  // Called right after the edge that captured the last sample.
  task automatic finish_window(input string tag);
    int p0;
    win_stats(rq, e_rac, e_rdc);
    win_stats(iq, e_iac, e_idc);
    e_beat = m_beat;
    p0 = sv_pulses;
    check({tag, "/sv_e0"}, 32'(bus.Stats_Valid), 0);
    junk_on();
    tick();
    check({tag, "/sv_e1"}, 32'(bus.Stats_Valid), 0);
    check({tag, "/busy_e1"}, 32'(bus.Busy), 1);
    junk_on();
    tick();
    bus.RED_Valid = 1'b0;
    bus.IR_Valid  = 1'b0;
    check({tag, "/sv_e2"}, 32'(bus.Stats_Valid), 1);
    check({tag, "/red_ac"}, 32'(bus.RED_AC), 32'(e_rac));
    check({tag, "/red_dc"}, 32'(bus.RED_DC), 32'(e_rdc));
    check({tag, "/ir_ac"}, 32'(bus.IR_AC), 32'(e_iac));
    check({tag, "/ir_dc"}, 32'(bus.IR_DC), 32'(e_idc));
    check({tag, "/beats"}, 32'(bus.Beat_Count), 32'(e_beat));
    check({tag, "/pulses"}, 32'(sv_pulses), 32'(p0 + 1));
    rq.delete();
    iq.delete();
    m_beat = 0;
    m_act = bus.Enable;
  endtask

  task automatic check_held(input string tag);
    check({tag, "/red_ac"}, 32'(bus.RED_AC), 32'(e_rac));
    check({tag, "/red_dc"}, 32'(bus.RED_DC), 32'(e_rdc));
    check({tag, "/ir_ac"}, 32'(bus.IR_AC), 32'(e_iac));
    check({tag, "/ir_dc"}, 32'(bus.IR_DC), 32'(e_idc));
    check({tag, "/beats"}, 32'(bus.Beat_Count), 32'(e_beat));
  endtask

  task automatic random_window(input string tag);
    int it;
    it = 0;
    while ((rq.size() < N || iq.size() < N) && it < 2000) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      it++;
    end
    finish_window(tag);
  endtask

  initial begin
    int p;
    int v;
    rst = 1'b1;
    bus.Enable        = 1'b0;
    bus.RED_Valid     = 1'b0;
    bus.IR_Valid      = 1'b0;
    bus.RED_ADC_Value = '0;
    bus.IR_ADC_Value  = '0;
    m_act = 0;
    m_beat = 0;
    tick();
    tick();
    check("rst/red_ac", 32'(bus.RED_AC), 0);
    check("rst/red_dc", 32'(bus.RED_DC), 0);
    check("rst/ir_ac", 32'(bus.IR_AC), 0);
    check("rst/ir_dc", 32'(bus.IR_DC), 0);
    check("rst/beats", 32'(bus.Beat_Count), 0);
    check("rst/sv", 32'(bus.Stats_Valid), 0);
    check("rst/busy", 32'(bus.Busy), 0);
    bus.Enable = 1'b1;
    tick();
    check("rst/busy_en", 32'(bus.Busy), 0);
    rst = 1'b0;
    tick();
    check("start/busy", 32'(bus.Busy), 1);
    fresh_start();

    // Triangle on IR, random RED, both strobed every cycle.
    for (int i = 0; i < N; i++) begin
      p = i % 20;
      v = (p <= 10) ? 100 + 4 * p : 140 - 4 * (p - 10);
      send(1'b1, int'($urandom_range(0, 255)), 1'b1, v);
    end
    finish_window("tri");
    check("tri/beats3", 32'(bus.Beat_Count), 3);
    check("tri/ir_ac40", 32'(bus.IR_AC), 40);

    // Constant levels, channels strobed on alternate cycles.
    for (int i = 0; i < N; i++) begin
      send(1'b1, 100, 1'b0, 0);
      send(1'b0, 0, 1'b1, 150);
    end
    finish_window("const");
    check("const/red_dc100", 32'(bus.RED_DC), 100);
    check("const/ir_dc150", 32'(bus.IR_DC), 150);

    random_window("rnd0");
    random_window("rnd1");
    check_held("hold");

    // RED overrun: 80 RED before any IR.
    for (int i = 0; i < 80; i++)
      send(1'b1, int'($urandom_range(0, 255)), 1'b0, 0);
    for (int i = 0; i < N; i++)
      send(1'b0, 0, 1'b1, int'($urandom_range(0, 255)));
    finish_window("over");

    // Abort mid-window, strobes while idle, then a clean window.
    p = sv_pulses;
    for (int i = 0; i < 30; i++)
      send(1'b1, int'($urandom_range(0, 255)), 1'b1,
           int'($urandom_range(0, 255)));
    bus.Enable = 1'b0;
    m_act = 0;
    tick();
    check("abort/busy", 32'(bus.Busy), 0);
    send(1'b1, 7, 1'b1, 9);
    send(1'b1, 7, 1'b1, 9);
    check("abort/nopulse", 32'(sv_pulses), 32'(p));
    check_held("abort");
    bus.Enable = 1'b1;
    tick();
    fresh_start();
    for (int i = 0; i < N; i++) send(1'b1, 50, 1'b1, 60);
    finish_window("reen");
    check("reen/red_dc50", 32'(bus.RED_DC), 50);
    check("reen/ir_dc60", 32'(bus.IR_DC), 60);
    check("reen/pulses", 32'(sv_pulses), 32'(p + 1));

    random_window("rnd2");

    // Reset mid-window.
    for (int i = 0; i < 20; i++)
      send(1'b1, int'($urandom_range(1, 255)), 1'b1,
           int'($urandom_range(1, 255)));
    rst = 1'b1;
    #1;
    check("mrst/red_ac", 32'(bus.RED_AC), 0);
    check("mrst/red_dc", 32'(bus.RED_DC), 0);
    check("mrst/ir_ac", 32'(bus.IR_AC), 0);
    check("mrst/ir_dc", 32'(bus.IR_DC), 0);
    check("mrst/beats", 32'(bus.Beat_Count), 0);
    check("mrst/busy", 32'(bus.Busy), 0);
    m_act = 0;
    p = sv_pulses;
    tick();
    rst = 1'b0;
    tick();
    fresh_start();
    for (int i = 0; i < N - 1; i++)
      send(1'b1, int'($urandom_range(0, 255)), 1'b1,
           int'($urandom_range(0, 255)));
    check("mrst/nopulse", 32'(sv_pulses), 32'(p));
    check("mrst/dc_still0", 32'(bus.RED_DC), 0);
    send(1'b1, int'($urandom_range(0, 255)), 1'b1,
         int'($urandom_range(0, 255)));
    finish_window("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
